prefix_adder_arbiter: RTL and testbench

Shares one combinational W-bit parallel-prefix adder (the G/P tree of black and grey cells) among N requesters. A round-robin arbiter locks the adder to one requester for a whole multi-word burst. Between words of a burst, the controller chains the carry so that wide operands are added least-significant word first. Results leave through a one-entry registered valid/ready output stage tagged with the requester ID.

---
 rtl/prefix_adder_arbiter_if.sv | 43 ++++
 rtl/prefix_adder_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_prefix_adder_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prefix_adder_arbiter_if.sv
// Bundle of the request lanes, the shared-adder hookup and the result stage
// for prefix_adder_arbiter. The slave modport is the arbiter's side; the
// master modport is the side that owns the requesters, the adder and the
// result consumer.
interface prefix_adder_arbiter_if #(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4
);
    localparam int unsigned IdW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_last;

    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic [IdW-1:0] res_id;
    logic           res_last;
    logic           busy;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last, add_sum, add_cout, res_ready,
        output req_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, res_id,
               res_last, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last, add_sum, add_cout, res_ready,
        input  req_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, res_id,
               res_last, busy
    );
endinterface

// File: rtl/prefix_adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among N
// requesters. A grant is held for a whole burst; results leave through a
// one-entry registered valid/ready stage tagged with the requester index.
// Optional feature macro: ADDER_CARRY_CHAIN_EN enables multi-word bursts with
// carry chaining between words. Without it every word is a burst of one.
module prefix_adder_arbiter #(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4
) (
    input logic                   clk,
    input logic                   rst,
    prefix_adder_arbiter_if.slave bus
);
    localparam int unsigned IdW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] pick;
    logic           found;
    logic           accept;
    logic           last_word;
    logic           lane_valid;
    logic           lane_cin;

    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_sum_q, res_sum_d;
    logic           res_cout_q, res_cout_d;
    logic [IdW-1:0] res_id_q, res_id_d;
    logic           res_last_q, res_last_d;

`ifdef ADDER_CARRY_CHAIN_EN
    logic           carry_q, carry_d;
    logic           first_q, first_d;
`else
    logic           unused_last;
    assign unused_last = ^bus.req_last;
`endif

    logic [W-1:0] lane_a [N];
    logic [W-1:0] lane_b [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_lanes
        assign lane_a[gi] = bus.req_a[gi*W +: W];
        assign lane_b[gi] = bus.req_b[gi*W +: W];
    end

    assign lane_valid = bus.req_valid[grant_q];
    assign lane_cin   = bus.req_cin[grant_q];
    assign accept     = (state_q == StBurst) && lane_valid && (!res_valid_q || bus.res_ready);

`ifdef ADDER_CARRY_CHAIN_EN
    assign last_word = bus.req_last[grant_q];
`else
    assign last_word = 1'b1;
`endif

    // Round-robin search: first valid requester at or after rr_ptr_q.
    always_comb begin
        logic [IdW-1:0] idx;
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = IdW'((int'(rr_ptr_q) + k) % int'(N));
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // FSM next state, grant capture and pointer rotation after a last word.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (accept && last_word) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_q == IdW'(N - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Adder operand mux; carry-in depends only on grant and burst position.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (state_q == StBurst) begin
            bus.add_a = lane_a[grant_q];
            bus.add_b = lane_b[grant_q];
`ifdef ADDER_CARRY_CHAIN_EN
            bus.add_cin = first_q ? lane_cin : carry_q;
`else
            bus.add_cin = lane_cin;
`endif
        end
    end

    // Only the granted lane ever sees ready.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            bus.req_ready[i] = accept && (grant_q == IdW'(i));
        end
    end

    // Result register: load on accept, otherwise drain on res_ready.
    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
        res_last_d  = res_last_q;
`ifdef ADDER_CARRY_CHAIN_EN
        carry_d     = carry_q;
        first_d     = first_q;
        if (state_q == StIdle) begin
            first_d = 1'b1;
        end
`endif
        if (accept) begin
            res_valid_d = 1'b1;
            res_sum_d   = bus.add_sum;
            res_cout_d  = bus.add_cout;
            res_id_d    = grant_q;
            res_last_d  = last_word;
`ifdef ADDER_CARRY_CHAIN_EN
            carry_d     = bus.add_cout;
            first_d     = 1'b0;
`endif
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a partial burst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
            res_last_q  <= 1'b0;
`ifdef ADDER_CARRY_CHAIN_EN
            carry_q     <= 1'b0;
            first_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
            res_last_q  <= res_last_d;
`ifdef ADDER_CARRY_CHAIN_EN
            carry_q     <= carry_d;
            first_q     <= first_d;
`endif
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_last  = res_last_q;
    assign bus.busy      = (state_q == StBurst);
endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// Cycle-table bench for prefix_adder_arbiter (W=16, N=4). Each row gives the
// inputs for one cycle and the outputs expected in that cycle before the next
// rising edge. The granted-looking lane carries the row operands; every other
// lane carries distinct filler operands so a wrong lane select shows in the sum.
module tb_prefix_adder_arbiter;
    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        int          lane;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        last;
        logic        rdy;
        logic [3:0]  er;
        logic        eb;
        logic        erv;
        logic [15:0] es;
        logic        ec;
        logic [1:0]  eid;
        logic        erl;
    } row_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    prefix_adder_arbiter_if #(.W(W), .N(N)) bus ();

    prefix_adder_arbiter #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared adder model.
    logic [16:0] add_full;
    assign add_full     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'b0, bus.add_cin};
    assign bus.add_sum  = add_full[15:0];
    assign bus.add_cout = add_full[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic row_t mk(input logic r, input logic [3:0] v, input int lane,
                                input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic last, input logic rdy, input logic [3:0] er,
                                input logic eb, input logic erv, input logic [15:0] es,
                                input logic ec, input logic [1:0] eid, input logic erl);
        row_t x;
        x.rst = r;   x.v = v;     x.lane = lane; x.a = a;     x.b = b;
        x.cin = cin; x.last = last; x.rdy = rdy; x.er = er;   x.eb = eb;
        x.erv = erv; x.es = es;   x.ec = ec;     x.eid = eid; x.erl = erl;
        return x;
    endfunction

    task automatic drive(input row_t r);
        rst           = r.rst;
        bus.req_valid = r.v;
        bus.res_ready = r.rdy;
        for (int i = 0; i < int'(N); i++) begin
            if (i == r.lane) begin
                bus.req_a[i*W +: W] = r.a;
                bus.req_b[i*W +: W] = r.b;
                bus.req_cin[i]      = r.cin;
                bus.req_last[i]     = r.last;
            end else begin
                bus.req_a[i*W +: W] = 16'hDEAD;
                bus.req_b[i*W +: W] = 16'hBEEF;
                bus.req_cin[i]      = 1'b1;
                bus.req_last[i]     = 1'b1;
            end
        end
    endtask

    task automatic cmp(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h required %0h", nm, field, act, exp);
        end
    endtask

    task automatic check(input row_t r, input string nm);
        cmp(nm, "req_ready", 32'(bus.req_ready), 32'(r.er));
        cmp(nm, "busy",      32'(bus.busy),      32'(r.eb));
        cmp(nm, "res_valid", 32'(bus.res_valid), 32'(r.erv));
        cmp(nm, "res_sum",   32'(bus.res_sum),   32'(r.es));
        cmp(nm, "res_cout",  32'(bus.res_cout),  32'(r.ec));
        cmp(nm, "res_id",    32'(bus.res_id),    32'(r.eid));
        cmp(nm, "res_last",  32'(bus.res_last),  32'(r.erl));
    endtask

    // Drive at posedge+1, check at the falling edge, then advance one cycle.
    task automatic run_row(input row_t r, input string nm);
        drive(r);
        @(negedge clk);
        check(r, nm);
        @(posedge clk);
        #1;
    endtask

    row_t tbl[$];
    row_t chn[$];
    row_t r_mid;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Single word from requester 2, acceptance after one bubble.
        tbl.push_back(mk(0, 4'b0100, 2, 16'h00FF, 16'h0001, 0, 1, 1, 4'b0000, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 2, 16'h00FF, 16'h0001, 0, 1, 1, 4'b0100, 1, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 2, 16'h00FF, 16'h0001, 0, 1, 1, 4'b0000, 0, 1, 16'h0100, 0, 2, 1));
        // All four valid: order 3,0,1,2,3,0 since the pointer now sits at 3.
        tbl.push_back(mk(0, 4'b1111, 3, 16'h0001, 16'h0002, 1, 1, 1, 4'b0000, 0, 0, 16'h0100, 0, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 3, 16'h0001, 16'h0002, 1, 1, 1, 4'b1000, 1, 0, 16'h0100, 0, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 16'hFFFF, 16'h0001, 0, 1, 1, 4'b0000, 0, 1, 16'h0004, 0, 3, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 16'hFFFF, 16'h0001, 0, 1, 1, 4'b0001, 1, 0, 16'h0004, 0, 3, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 16'h1234, 16'h1111, 0, 1, 1, 4'b0000, 0, 1, 16'h0000, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 16'h1234, 16'h1111, 0, 1, 1, 4'b0010, 1, 0, 16'h0000, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 2, 16'h8000, 16'h8000, 1, 1, 1, 4'b0000, 0, 1, 16'h2345, 0, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 2, 16'h8000, 16'h8000, 1, 1, 1, 4'b0100, 1, 0, 16'h2345, 0, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 3, 16'h0F0F, 16'hF0F0, 0, 1, 1, 4'b0000, 0, 1, 16'h0001, 1, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 3, 16'h0F0F, 16'hF0F0, 0, 1, 1, 4'b1000, 1, 0, 16'h0001, 1, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 16'hABCD, 16'h0000, 0, 1, 1, 4'b0000, 0, 1, 16'hFFFF, 0, 3, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 16'hABCD, 16'h0000, 0, 1, 1, 4'b0001, 1, 0, 16'hFFFF, 0, 3, 1));
        // Backpressure: result held, no accept while res_ready is low.
        tbl.push_back(mk(0, 4'b0010, 1, 16'h0001, 16'h0001, 0, 1, 0, 4'b0000, 0, 1, 16'hABCD, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 16'h0001, 16'h0001, 0, 1, 0, 4'b0000, 1, 1, 16'hABCD, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 16'h0001, 16'h0001, 0, 1, 0, 4'b0000, 1, 1, 16'hABCD, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 16'h0001, 16'h0001, 0, 1, 0, 4'b0000, 1, 1, 16'hABCD, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 16'h0001, 16'h0001, 0, 1, 1, 4'b0010, 1, 1, 16'hABCD, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 16'h0001, 16'h0001, 0, 1, 1, 4'b0000, 0, 1, 16'h0002, 0, 1, 1));
        // Lock: granted lane 2 drops valid while lane 3 waits; no preemption.
        tbl.push_back(mk(0, 4'b0100, 2, 16'h0003, 16'h0004, 0, 1, 1, 4'b0000, 0, 0, 16'h0002, 0, 1, 1));
        tbl.push_back(mk(0, 4'b1000, 2, 16'h0003, 16'h0004, 0, 1, 1, 4'b0000, 1, 0, 16'h0002, 0, 1, 1));
        tbl.push_back(mk(0, 4'b1000, 2, 16'h0003, 16'h0004, 0, 1, 1, 4'b0000, 1, 0, 16'h0002, 0, 1, 1));
        tbl.push_back(mk(0, 4'b1100, 2, 16'h0003, 16'h0004, 0, 1, 1, 4'b0100, 1, 0, 16'h0002, 0, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 2, 16'h0003, 16'h0004, 0, 1, 1, 4'b0000, 0, 1, 16'h0007, 0, 2, 1));
        tbl.push_back(mk(0, 4'b0000, 2, 16'h0003, 16'h0004, 0, 1, 1, 4'b0000, 0, 0, 16'h0007, 0, 2, 1));

        // Chained bursts: two words from lane 0, then three words from lane 1
        // with a stall after the first while lane 3 is waiting.
        chn.push_back(mk(0, 4'b0001, 0, 16'hFFFF, 16'h0001, 0, 0, 1, 4'b0000, 0, 0, 16'h0007, 0, 2, 1));
        chn.push_back(mk(0, 4'b0001, 0, 16'hFFFF, 16'h0001, 0, 0, 1, 4'b0001, 1, 0, 16'h0007, 0, 2, 1));
        chn.push_back(mk(0, 4'b0001, 0, 16'h0000, 16'h0000, 0, 1, 1, 4'b0001, 1, 1, 16'h0000, 1, 0, 0));
        chn.push_back(mk(0, 4'b1010, 1, 16'hFFFF, 16'hFFFF, 1, 0, 1, 4'b0000, 0, 1, 16'h0001, 0, 0, 1));
        chn.push_back(mk(0, 4'b1010, 1, 16'hFFFF, 16'hFFFF, 1, 0, 1, 4'b0010, 1, 0, 16'h0001, 0, 0, 1));
        chn.push_back(mk(0, 4'b1000, 1, 16'hFFFF, 16'hFFFF, 1, 0, 1, 4'b0000, 1, 1, 16'hFFFF, 1, 1, 0));
        chn.push_back(mk(0, 4'b1000, 1, 16'hFFFF, 16'hFFFF, 1, 0, 1, 4'b0000, 1, 0, 16'hFFFF, 1, 1, 0));
        chn.push_back(mk(0, 4'b1010, 1, 16'h0000, 16'hFFFF, 0, 0, 1, 4'b0010, 1, 0, 16'hFFFF, 1, 1, 0));
        chn.push_back(mk(0, 4'b1010, 1, 16'h0001, 16'h0002, 0, 1, 1, 4'b0010, 1, 1, 16'h0000, 1, 1, 0));
        chn.push_back(mk(0, 4'b1000, 1, 16'h0000, 16'h0000, 0, 1, 1, 4'b0000, 0, 1, 16'h0004, 0, 1, 1));

        // Reset state.
        drive(mk(1, 4'b0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 4'b0000, 0, 0, 16'h0000, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check(mk(1, 4'b0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 4'b0000, 0, 0, 16'h0000, 0, 0, 0),
              "reset");
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

`ifdef ADDER_CARRY_CHAIN_EN
        for (int i = 0; i < chn.size(); i++) begin
            run_row(chn[i], $sformatf("chain%0d", i));
        end
`endif

        // Reset mid-burst: a clean reset, one word from lane 2 with last low,
        // reset raised during the second word, then lane 0 must win using req_cin.
        drive(mk(1, 4'b0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 4'b0000, 0, 0, 16'h0000, 0, 0, 0));
        @(posedge clk);
        #1;
        run_row(mk(0, 4'b0100, 2, 16'h0001, 16'h0001, 0, 0, 1, 4'b0000, 0, 0, 16'h0000, 0, 0, 0),
                "rst_arb");
        run_row(mk(0, 4'b0100, 2, 16'h0001, 16'h0001, 0, 0, 1, 4'b0100, 1, 0, 16'h0000, 0, 0, 0),
                "rst_word1");
`ifdef ADDER_CARRY_CHAIN_EN
        r_mid = mk(1, 4'b0100, 2, 16'h0001, 16'h0001, 0, 0, 1, 4'b0100, 1, 1, 16'h0002, 0, 2, 0);
`else
        r_mid = mk(1, 4'b0100, 2, 16'h0001, 16'h0001, 0, 0, 1, 4'b0000, 0, 1, 16'h0002, 0, 2, 1);
`endif
        run_row(r_mid, "rst_word2");
        run_row(mk(0, 4'b1111, 0, 16'h0010, 16'h0020, 1, 1, 1, 4'b0000, 0, 0, 16'h0000, 0, 0, 0),
                "rst_after");
        run_row(mk(0, 4'b1111, 0, 16'h0010, 16'h0020, 1, 1, 1, 4'b0001, 1, 0, 16'h0000, 0, 0, 0),
                "rst_grant0");
        run_row(mk(0, 4'b0000, 0, 16'h0010, 16'h0020, 1, 1, 1, 4'b0000, 0, 1, 16'h0031, 0, 0, 1),
                "rst_result");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
